// File: rtl/mips_lite_pkg.sv
// mips_lite_pkg: shared opcodes, ALU/mux codes, control states and control word for the multi-cycle datapath
package mips_lite_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REXEC, S_RWB, S_BEQEX, S_JEX, S_AEXEC, S_AWB, S_TRAP
  } state_t;
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       trap;
  } ctrl_t;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state -> control-word decoder, memory handshakes gated by rdy
module mc_ctrl_decode
  import mips_lite_pkg::*;
(
  input  state_t state,
  input  logic   rdy,
  output ctrl_t  ctrl
);
  // every field defaults to 0; each state raises only what it needs
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = rdy;
        ctrl.pcwrite = rdy;
      end
      S_DECODE: ctrl.alusrcb = SRCB_IMM_SH2;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord = 1'b1;
        ctrl.instr_done = rdy;
      end
      S_REXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_JEX: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_AEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_AWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_TRAP: ctrl.trap = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS-lite main control FSM (state register and next-state logic)
module mc_main_control
  import mips_lite_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       aluop1,
  output logic       aluop0,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       trap
);
  state_t state, nxt;
  ctrl_t  ctrl;
  logic   rdy;
  assign rdy = USE_MEM_READY ? mem_ready : 1'b1;
  // state register, async reset straight into S_RST
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_RST;
    else state <= nxt;
  // next state; op is only consulted in DECODE and MEMADR, stray encodings recover via S_RST
  always_comb begin
    nxt = S_RST;
    case (state)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: nxt = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                      op == OP_RTYPE ? S_REXEC :
                      op == OP_BEQ   ? S_BEQEX :
                      op == OP_J     ? S_JEX :
                      op == OP_ADDI  ? S_AEXEC : S_TRAP;
      S_MEMADR: nxt = op == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
      S_REXEC:  nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_BEQEX:  nxt = S_FETCH;
      S_JEX:    nxt = S_FETCH;
      S_AEXEC:  nxt = S_AWB;
      S_AWB:    nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_RST;
    endcase
  end
  mc_ctrl_decode u_dec (
    .state(state),
    .rdy  (rdy),
    .ctrl (ctrl)
  );
  assign pcwrite     = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regdst      = ctrl.regdst;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign aluop1      = ctrl.aluop[1];
  assign aluop0      = ctrl.aluop[0];
  assign pcsource    = ctrl.pcsource;
  assign instr_done  = ctrl.instr_done;
  assign trap        = ctrl.trap;
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: randomized instruction streams checked against a per-instruction phase-plan model
module tb_mc_main_control;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = 6'd0;
  logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite;
  logic alusrca, aluop1, aluop0, instr_done, trap;
  logic [1:0] alusrcb, pcsource;
  logic [17:0] obs;
  int tests = 0, fails = 0, dn = 0;
  localparam int P_RST = 0, P_F = 1, P_D = 2, P_MA = 3, P_MR = 4, P_MWB = 5, P_MW = 6;
  localparam int P_RX = 7, P_RWB = 8, P_BQ = 9, P_J = 10, P_AX = 11, P_AWB = 12, P_TRAP = 13;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  logic [5:0] ops [6];
  mc_main_control #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop1(aluop1),
    .aluop0(aluop0), .pcsource(pcsource), .instr_done(instr_done), .trap(trap)
  );
  assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource, instr_done, trap};
  always #5 clk = ~clk;
  function automatic logic [17:0] ew(int p, bit r);
    logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0, d = 0, tr = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    case (p)
      P_F:    begin mr = 1; asb = 2'b01; irw = r; pw = r; end
      P_D:    asb = 2'b11;
      P_MA:   begin asa = 1; asb = 2'b10; end
      P_MR:   begin mr = 1; io = 1; end
      P_MWB:  begin rw = 1; m2r = 1; d = 1; end
      P_MW:   begin mw = 1; io = 1; d = r; end
      P_RX:   begin asa = 1; aop = 2'b10; end
      P_RWB:  begin rw = 1; rd = 1; d = 1; end
      P_BQ:   begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; d = 1; end
      P_J:    begin pw = 1; pcs = 2'b10; d = 1; end
      P_AX:   begin asa = 1; asb = 2'b10; end
      P_AWB:  begin rw = 1; d = 1; end
      P_TRAP: tr = 1;
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, d, tr};
  endfunction
  task automatic chk(string tag, logic [17:0] o, logic [17:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk_int(string tag, int o, int e);
    tests++;
    assert (o == e) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  task automatic step(int p, bit r, logic [5:0] o, bit hold, string tag);
    @(negedge clk);
    mem_ready = r;
    op = hold ? o : 6'($urandom);
    #1;
    chk(tag, obs, ew(p, r));
    if (instr_done) dn++;
  endtask
  task automatic wstep(int p, int n, logic [5:0] o, string tag, inout int cyc, inout int w);
    for (int i = 0; i < n; i++) step(p, 1'b0, o, 1'b0, tag);
    step(p, 1'b1, o, 1'b0, tag);
    cyc += n + 1;
    w += n;
  endtask
  task automatic run_instr(logic [5:0] o, int mw_wait);
    int cyc = 0, w = 0, base = 0;
    dn = 0;
    wstep(P_F, $urandom_range(0, 2), o, "fetch", cyc, w);
    step(P_D, 1'($urandom), o, 1'b1, "decode");
    cyc++;
    case (o)
      LW: begin
        step(P_MA, 1'($urandom), o, 1'b1, "lw_memadr");
        wstep(P_MR, $urandom_range(0, 2), o, "lw_memrd", cyc, w);
        step(P_MWB, 1'($urandom), o, 1'b0, "lw_memwb");
        cyc += 2; base = 5;
      end
      SW: begin
        step(P_MA, 1'($urandom), o, 1'b1, "sw_memadr");
        wstep(P_MW, mw_wait < 0 ? $urandom_range(0, 2) : mw_wait, o, "sw_memwr", cyc, w);
        cyc += 1; base = 4;
      end
      RT: begin
        step(P_RX, 1'($urandom), o, 1'b0, "rexec");
        step(P_RWB, 1'($urandom), o, 1'b0, "rwb");
        cyc += 2; base = 4;
      end
      BEQ: begin step(P_BQ, 1'($urandom), o, 1'b0, "beqex"); cyc += 1; base = 3; end
      JMP: begin step(P_J, 1'($urandom), o, 1'b0, "jex"); cyc += 1; base = 3; end
      default: begin
        step(P_AX, 1'($urandom), o, 1'b0, "aexec");
        step(P_AWB, 1'($urandom), o, 1'b0, "awb");
        cyc += 2; base = 4;
      end
    endcase
    chk_int("latency", cyc, base + w);
    chk_int("done_count", dn, 1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1 chk("rst_async", obs, 18'd0);
    @(negedge clk);
    #1 chk("rst_hold", obs, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release", obs, ew(P_RST, 1'b1));
  endtask
  initial begin
    ops = '{LW, SW, RT, BEQ, JMP, ADDI};
    do_reset();
    run_instr(LW, -1);
    run_instr(SW, 3);
    run_instr(RT, -1);
    run_instr(BEQ, -1);
    run_instr(JMP, -1);
    for (int k = 0; k < 40; k++) run_instr(ops[$urandom_range(0, 5)], -1);
    dn = 0;
    step(P_F, 1'b1, ADDI, 1'b0, "abort_fetch");
    step(P_D, 1'b1, ADDI, 1'b1, "abort_decode");
    step(P_AX, 1'b1, ADDI, 1'b0, "abort_aexec");
    do_reset();
    chk_int("abort_done", dn, 0);
    run_instr(ADDI, -1);
    step(P_F, 1'b1, 6'h3f, 1'b0, "trap_fetch");
    step(P_D, 1'b1, 6'h3f, 1'b1, "trap_decode");
    for (int k = 0; k < 12; k++) step(P_TRAP, 1'($urandom), 6'h3f, 1'b0, "trap_hold");
    do_reset();
    run_instr(ops[$urandom_range(0, 5)], -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
